mc_control_unit: RTL and testbench
==================================

# mc_control_unit

Parametrised multicycle RV32I control unit: a Moore FSM plus an ALU/immediate decoder that sequences the shared-memory datapath (PC, OldPC, IR, A/WriteData, ALUOut, Data registers). Unlike the previous controller it covers the full RV32I base branch set (beq/bne/blt/bge/bltu/bgeu via ALU flags), jal, jalr, lui and auipc. It also waits on a memory-ready handshake with an optional timeout, and can trap on illegal opcodes. It sits between the instruction register and the datapath multiplexers and write enables.

## Interface
- WAIT_MAX, 0: max consecutive not-ready memory cycles before fault; 0 means unbounded wait, no timeout logic.
- ALUCTRL_W, 4: width of o_alu_control (≥4); bits above [3] are driven 0.
- i_clk  in  1  clock; all state changes on the rising edge.
- i_rst  in  1  asynchronous, active-high reset.
- i_instr  in  32  instruction register contents.
- i_zero, i_neg, i_carry, i_ovf  in  1 each  ALU flags for A−B; i_carry=1 means no borrow.
- i_mem_ready  in  1  memory completes the requested access this cycle.
- o_mem_req  out  1  memory access request.
- o_mem_write  out  1  store strobe.
- o_adr_src  out  1  0: address = PC; 1: address = ALUOut.
- o_ir_write  out  1  load IR and OldPC.
- o_pc_write  out  1  load PC from Result.
- o_reg_write  out  1  register file write of Result to rd.
- o_result_src  out  2  00 ALUOut, 01 Data, 10 ALUResult.
- o_alu_src_a  out  2  00 PC, 01 OldPC, 10 A (rs1), 11 zero.
- o_alu_src_b  out  2  00 WriteData (rs2), 01 immediate, 10 constant 4.
- o_imm_src  out  3  000 I, 001 S, 010 B, 011 J, 100 U.
- o_alu_control  out  ALUCTRL_W  0 add, 1 sub, 2 sll, 3 slt, 4 sltu, 5 xor, 6 srl, 7 sra, 8 or, 9 and.
- o_state  out  4  current state encoding, for debug.
- o_fault  out  1  sticky fault flag; set by timeout or trap, cleared only by reset.

## Operation
- State encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, JAL=10, JALR=11, UPIMM=12, TRAP=13.
- FETCH
  - Outputs: mem_req=1, adr_src=0, srcA=00, srcB=10, add, result_src=10.
  - When i_mem_ready=1: ir_write=1, pc_write=1, go to DECODE. Otherwise hold in FETCH.
- DECODE
  - Outputs: srcA=01, srcB=01, add, imm_src taken from opcode. This computes the branch/jal target into ALUOut.
  - Next state by opcode: 0000011→MEMADR; 0100011→MEMADR; 0110011→EXECR; 0010011→EXECI; 1100011→BRANCH; 1101111→JAL; 1100111→JALR; 0110111, 0010111→UPIMM.
- MEMADR: srcA=10, srcB=01, add. Loads go to MEMREAD; stores go to MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1. Go to MEMWB on ready, otherwise hold.
- MEMWB: result_src=01, reg_write=1, then FETCH.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Go to FETCH on ready, otherwise hold.
- EXECR: srcA=10, srcB=00, ALU op from funct3/funct7[5]. funct7[5] selects sub/sra. Then ALUWB.
- EXECI: srcA=10, srcB=01. funct7[5] selects sra only for funct3=101; addi never becomes sub. Then ALUWB.
- ALUWB: result_src=00, reg_write=1, then FETCH.
- BRANCH
  - Outputs: srcA=10, srcB=00, sub, result_src=00.
  - pc_write is asserted when the condition holds. Conditions by funct3:
    - 000: zero
    - 001: !zero
    - 100: neg^ovf
    - 101: !(neg^ovf)
    - 110: !carry
    - 111: carry
  - Then FETCH.
- JAL: srcA=01, srcB=10, add, result_src=00, pc_write=1, then ALUWB. ALUOut then holds PC+4 for the rd write.
- JALR: srcA=10, srcB=01, add, imm I, then JAL. The target rs1+imm is carried through ALUOut. Bit 0 clearing is done by the datapath.
- UPIMM: imm U, srcB=01, add, then ALUWB. srcA=11 for lui; srcA=01 for auipc.
- TRAP: all strobes 0, o_fault=1. Held until reset.
- Unlisted outputs are 0 in each state.

## Timing
- State, wait counter and o_fault are registered. All other outputs are combinational from the state, i_instr, the flags and i_mem_ready.
- While i_rst=1: state=FETCH, counter=0, o_fault=0, o_state=0. mem_req, mem_write, ir_write, pc_write and reg_write are forced 0. Reset deassertion mid-instruction restarts at FETCH.
- Zero-wait cycle counts:
  - branch 3
  - R/I-ALU, store, jal, lui/auipc 4
  - load, jalr 5
- Each not-ready cycle in FETCH/MEMREAD/MEMWRITE adds one cycle.
- Wait counter (WAIT_MAX>0)
  - Increments on each not-ready cycle in FETCH/MEMREAD/MEMWRITE. Clears on ready and on leaving those states.
  - When the counter equals WAIT_MAX−1 with ready still low, the next state is TRAP.
  - If ready arrives in that same cycle, it wins and no trap occurs.

## Configuration
- CTRL_ILLEGAL_TRAP_EN defined: the following go to TRAP on the next edge and set o_fault:
  - unknown opcode in DECODE
  - branch funct3 010/011
- Undefined: an unknown opcode goes DECODE→FETCH as a NOP, with PC already advanced. Branch funct3 010/011 is not-taken. o_fault is set only by timeout.

## Test plan
- add x3,x1,x2 with ready tied 1 → states 0,1,6,8,0. reg_write=1 only in ALUWB. alu_control=0 in EXECR.
- bltu with i_carry=0 → pc_write=1 in BRANCH. With i_carry=1 → pc_write=0. Either way 3 cycles.
- lw with ready low for 3 cycles in MEMREAD → 8 cycles total. result_src=01 and reg_write=1 in MEMWB.
- WAIT_MAX=4, ready held 0 in FETCH → TRAP on the 5th edge. o_fault=1. Strobes stay 0 until i_rst.
- Opcode 0000000 → with CTRL_ILLEGAL_TRAP_EN: TRAP, o_fault=1. Without: FETCH follows DECODE, o_fault=0.
- jalr: assert i_rst mid-sequence (in JAL) → strobes 0 immediately. Execution resumes at FETCH after release.

Source files
------------

// File: rtl/mc_control_unit.sv
// Multicycle RV32I control unit: Moore FSM sequencing a shared-memory datapath.
// Define CTRL_ILLEGAL_TRAP_EN to trap on unknown opcodes and branch funct3 010/011.
module mc_control_unit #(
    parameter int unsigned WAIT_MAX  = 0,
    parameter int unsigned ALUCTRL_W = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [31:0]          i_instr,
    input  logic                 i_zero,
    input  logic                 i_neg,
    input  logic                 i_carry,
    input  logic                 i_ovf,
    input  logic                 i_mem_ready,
    output logic                 o_mem_req,
    output logic                 o_mem_write,
    output logic                 o_adr_src,
    output logic                 o_ir_write,
    output logic                 o_pc_write,
    output logic                 o_reg_write,
    output logic [1:0]           o_result_src,
    output logic [1:0]           o_alu_src_a,
    output logic [1:0]           o_alu_src_b,
    output logic [2:0]           o_imm_src,
    output logic [ALUCTRL_W-1:0] o_alu_control,
    output logic [3:0]           o_state,
    output logic                 o_fault
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecR    = 4'd6,
        StExecI    = 4'd7,
        StAluWb    = 4'd8,
        StBranch   = 4'd9,
        StJal      = 4'd10,
        StJalr     = 4'd11,
        StUpImm    = 4'd12,
        StTrap     = 4'd13
    } state_e;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    localparam logic [3:0] AluAdd = 4'd0;
    localparam logic [3:0] AluSub = 4'd1;

    localparam logic [2:0] ImmI = 3'b000;
    localparam logic [2:0] ImmS = 3'b001;
    localparam logic [2:0] ImmB = 3'b010;
    localparam logic [2:0] ImmJ = 3'b011;
    localparam logic [2:0] ImmU = 3'b100;

    state_e      state_q, state_d;
    logic        fault_q;
    logic        timeout;
    logic        mem_req, mem_write, ir_write, pc_write, reg_write;
    logic [3:0]  alu_op;
    logic        take;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        unused_instr;

    assign opcode       = i_instr[6:0];
    assign funct3       = i_instr[14:12];
    assign unused_instr = ^{i_instr[31], i_instr[29:15], i_instr[11:7]};

    // alt selects sub (funct3 000) or sra (funct3 101)
    function automatic logic [3:0] alu_decode(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? AluSub : AluAdd;
            3'b001:  return 4'd2;
            3'b010:  return 4'd3;
            3'b011:  return 4'd4;
            3'b100:  return 4'd5;
            3'b101:  return alt ? 4'd7 : 4'd6;
            3'b110:  return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic logic [2:0] imm_decode(input logic [6:0] op);
        case (op)
            OpStore:         return ImmS;
            OpBranch:        return ImmB;
            OpJal:           return ImmJ;
            OpLui, OpAuipc:  return ImmU;
            default:         return ImmI;
        endcase
    endfunction

    always_comb begin
        case (funct3)
            3'b000:  take = i_zero;
            3'b001:  take = ~i_zero;
            3'b100:  take = i_neg ^ i_ovf;
            3'b101:  take = ~(i_neg ^ i_ovf);
            3'b110:  take = ~i_carry;
            3'b111:  take = i_carry;
            default: take = 1'b0;
        endcase
    end

    generate
        if (WAIT_MAX > 0) begin : g_wait
            localparam int unsigned CntW = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
            logic [CntW-1:0] cnt_q;
            logic            waiting;

            assign waiting = ((state_q == StFetch) || (state_q == StMemRead) ||
                              (state_q == StMemWrite)) && !i_mem_ready;
            assign timeout = waiting && (cnt_q == CntW'(WAIT_MAX - 1));

            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    cnt_q <= '0;
                end else if (waiting && !timeout) begin
                    cnt_q <= cnt_q + 1'b1;
                end else begin
                    cnt_q <= '0;
                end
            end
        end else begin : g_no_wait
            assign timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= StFetch;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fault_q <= fault_q | (state_d == StTrap);
        end
    end

    always_comb begin
        state_d      = state_q;
        mem_req      = 1'b0;
        mem_write    = 1'b0;
        ir_write     = 1'b0;
        pc_write     = 1'b0;
        reg_write    = 1'b0;
        o_adr_src    = 1'b0;
        o_result_src = 2'b00;
        o_alu_src_a  = 2'b00;
        o_alu_src_b  = 2'b00;
        o_imm_src    = ImmI;
        alu_op       = AluAdd;
        unique case (state_q)
            StFetch: begin
                mem_req      = 1'b1;
                o_alu_src_b  = 2'b10;
                o_result_src = 2'b10;
                if (i_mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = StDecode;
                end else if (timeout) begin
                    state_d = StTrap;
                end
            end
            StDecode: begin
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b01;
                o_imm_src   = imm_decode(opcode);
                case (opcode)
                    OpLoad, OpStore: state_d = StMemAdr;
                    OpR:             state_d = StExecR;
                    OpI:             state_d = StExecI;
                    OpBranch:        state_d = StBranch;
                    OpJal:           state_d = StJal;
                    OpJalr:          state_d = StJalr;
                    OpLui, OpAuipc:  state_d = StUpImm;
`ifdef CTRL_ILLEGAL_TRAP_EN
                    default:         state_d = StTrap;
`else
                    default:         state_d = StFetch;
`endif
                endcase
            end
            StMemAdr: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
                // Stores need the S-format offset here, loads the I-format one.
                o_imm_src   = imm_decode(opcode);
                state_d     = opcode[5] ? StMemWrite : StMemRead;
            end
            StMemRead: begin
                mem_req   = 1'b1;
                o_adr_src = 1'b1;
                if (i_mem_ready) begin
                    state_d = StMemWb;
                end else if (timeout) begin
                    state_d = StTrap;
                end
            end
            StMemWb: begin
                o_result_src = 2'b01;
                reg_write    = 1'b1;
                state_d      = StFetch;
            end
            StMemWrite: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                o_adr_src = 1'b1;
                if (i_mem_ready) begin
                    state_d = StFetch;
                end else if (timeout) begin
                    state_d = StTrap;
                end
            end
            StExecR: begin
                o_alu_src_a = 2'b10;
                alu_op      = alu_decode(funct3, i_instr[30]);
                state_d     = StAluWb;
            end
            StExecI: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
                alu_op      = alu_decode(funct3, i_instr[30] && (funct3 == 3'b101));
                state_d     = StAluWb;
            end
            StAluWb: begin
                reg_write = 1'b1;
                state_d   = StFetch;
            end
            StBranch: begin
                o_alu_src_a = 2'b10;
                alu_op      = AluSub;
                pc_write    = take;
                state_d     = StFetch;
`ifdef CTRL_ILLEGAL_TRAP_EN
                if (funct3[2:1] == 2'b01) begin
                    state_d = StTrap;
                end
`endif
            end
            StJal: begin
                o_alu_src_a = 2'b01;
                o_alu_src_b = 2'b10;
                pc_write    = 1'b1;
                state_d     = StAluWb;
            end
            StJalr: begin
                o_alu_src_a = 2'b10;
                o_alu_src_b = 2'b01;
                state_d     = StJal;
            end
            StUpImm: begin
                o_alu_src_a = (opcode == OpLui) ? 2'b11 : 2'b01;
                o_alu_src_b = 2'b01;
                o_imm_src   = ImmU;
                state_d     = StAluWb;
            end
            StTrap: begin
                state_d = StTrap;
            end
            default: begin
                state_d = StFetch;
            end
        endcase
    end

    // Strobes are suppressed combinationally so reset takes effect mid-cycle.
    assign o_mem_req     = mem_req & ~i_rst;
    assign o_mem_write   = mem_write & ~i_rst;
    assign o_ir_write    = ir_write & ~i_rst;
    assign o_pc_write    = pc_write & ~i_rst;
    assign o_reg_write   = reg_write & ~i_rst;
    assign o_alu_control = ALUCTRL_W'(alu_op);
    assign o_state       = state_q;
    assign o_fault       = fault_q;

endmodule

// File: tb/tb_mc_control_unit.sv
// Self-checking bench for mc_control_unit: directed sequences plus randomized traffic
// compared every cycle against an instruction-plan reference model.
module tb_mc_control_unit;

    localparam int unsigned WaitMax = 4;
    localparam int unsigned AluW    = 6;

    localparam logic [6:0] OpLoad   = 7'b0000011;
    localparam logic [6:0] OpStore  = 7'b0100011;
    localparam logic [6:0] OpR      = 7'b0110011;
    localparam logic [6:0] OpI      = 7'b0010011;
    localparam logic [6:0] OpBranch = 7'b1100011;
    localparam logic [6:0] OpJal    = 7'b1101111;
    localparam logic [6:0] OpJalr   = 7'b1100111;
    localparam logic [6:0] OpLui    = 7'b0110111;
    localparam logic [6:0] OpAuipc  = 7'b0010111;

    logic            clk;
    logic            i_rst;
    logic [31:0]     i_instr;
    logic            i_zero, i_neg, i_carry, i_ovf, i_mem_ready;
    logic            o_mem_req, o_mem_write, o_adr_src, o_ir_write, o_pc_write, o_reg_write;
    logic [1:0]      o_result_src, o_alu_src_a, o_alu_src_b;
    logic [2:0]      o_imm_src;
    logic [AluW-1:0] o_alu_control;
    logic [3:0]      o_state;
    logic            o_fault;

    mc_control_unit #(
        .WAIT_MAX  (WaitMax),
        .ALUCTRL_W (AluW)
    ) dut (
        .i_clk         (clk),
        .i_rst         (i_rst),
        .i_instr       (i_instr),
        .i_zero        (i_zero),
        .i_neg         (i_neg),
        .i_carry       (i_carry),
        .i_ovf         (i_ovf),
        .i_mem_ready   (i_mem_ready),
        .o_mem_req     (o_mem_req),
        .o_mem_write   (o_mem_write),
        .o_adr_src     (o_adr_src),
        .o_ir_write    (o_ir_write),
        .o_pc_write    (o_pc_write),
        .o_reg_write   (o_reg_write),
        .o_result_src  (o_result_src),
        .o_alu_src_a   (o_alu_src_a),
        .o_alu_src_b   (o_alu_src_b),
        .o_imm_src     (o_imm_src),
        .o_alu_control (o_alu_control),
        .o_state       (o_state),
        .o_fault       (o_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: per-instruction list of states after FETCH
    int   m_st    = 0;
    int   m_wait  = 0;
    logic m_fault = 1'b0;
    int   m_plan[6];
    int   m_len   = 0;
    int   m_pos   = 0;

    function automatic void load_plan(input logic [31:0] ins);
        logic bad_br;
        bad_br = (ins[14:12] == 3'b010) || (ins[14:12] == 3'b011);
        m_pos = 0;
        case (ins[6:0])
            OpLoad:         begin m_plan = '{1, 2, 3, 4, 0, 0};   m_len = 4; end
            OpStore:        begin m_plan = '{1, 2, 5, 0, 0, 0};   m_len = 3; end
            OpR:            begin m_plan = '{1, 6, 8, 0, 0, 0};   m_len = 3; end
            OpI:            begin m_plan = '{1, 7, 8, 0, 0, 0};   m_len = 3; end
            OpJal:          begin m_plan = '{1, 10, 8, 0, 0, 0};  m_len = 3; end
            OpJalr:         begin m_plan = '{1, 11, 10, 8, 0, 0}; m_len = 4; end
            OpLui, OpAuipc: begin m_plan = '{1, 12, 8, 0, 0, 0};  m_len = 3; end
            OpBranch: begin
                m_plan = '{1, 9, 13, 0, 0, 0};
`ifdef CTRL_ILLEGAL_TRAP_EN
                m_len = bad_br ? 3 : 2;
`else
                m_len = 2;
`endif
            end
            default: begin
                m_plan = '{1, 13, 0, 0, 0, 0};
`ifdef CTRL_ILLEGAL_TRAP_EN
                m_len = 2;
`else
                m_len = 1;
`endif
            end
        endcase
    endfunction

    function automatic int next_step();
        if (m_pos < m_len) begin
            m_pos++;
            return m_plan[m_pos-1];
        end
        return 0;
    endfunction

    initial forever begin
        int nxt;
        @(posedge clk or posedge i_rst);
        if (i_rst) begin
            m_st = 0; m_wait = 0; m_fault = 1'b0; m_len = 0; m_pos = 0;
        end else begin
            nxt = m_st;
            if (m_st == 13) begin
                nxt = 13;
            end else if (m_st == 0 || m_st == 3 || m_st == 5) begin
                if (i_mem_ready) begin
                    m_wait = 0;
                    if (m_st == 0) load_plan(i_instr);
                    nxt = next_step();
                end else begin
                    m_wait++;
                    if (WaitMax != 0 && m_wait == int'(WaitMax)) nxt = 13;
                end
            end else begin
                m_wait = 0;
                nxt = next_step();
            end
            if (nxt == 13) m_fault = 1'b1;
            m_st = nxt;
        end
    end

    typedef struct packed {
        logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
        logic [1:0] result_src, src_a, src_b;
        logic [2:0] imm;
        logic [3:0] alu;
    } outs_t;

    function automatic logic [2:0] imm_exp(input logic [6:0] op);
        if (op == OpStore) return 3'd1;
        if (op == OpBranch) return 3'd2;
        if (op == OpJal) return 3'd3;
        if (op == OpLui || op == OpAuipc) return 3'd4;
        return 3'd0;
    endfunction

    function automatic logic [3:0] alu_exp(input logic [2:0] f3, input logic b5, input bit is_r);
        case (f3)
            3'd0: return (is_r && b5) ? 4'd1 : 4'd0;
            3'd1: return 4'd2;
            3'd2: return 4'd3;
            3'd3: return 4'd4;
            3'd4: return 4'd5;
            3'd5: return b5 ? 4'd7 : 4'd6;
            3'd6: return 4'd8;
            default: return 4'd9;
        endcase
    endfunction

    function automatic outs_t expect_outs(input int s, input logic [31:0] ins, input logic rdy,
                                          input logic rst);
        outs_t e;
        logic [2:0] f3;
        logic lt;
        e  = '0;
        f3 = ins[14:12];
        lt = i_neg ^ i_ovf;
        case (s)
            0:  begin e.mem_req = 1; e.src_b = 2; e.result_src = 2;
                      e.ir_write = rdy; e.pc_write = rdy; end
            1:  begin e.src_a = 1; e.src_b = 1; e.imm = imm_exp(ins[6:0]); end
            2:  begin e.src_a = 2; e.src_b = 1; e.imm = imm_exp(ins[6:0]); end
            3:  begin e.mem_req = 1; e.adr_src = 1; end
            4:  begin e.result_src = 1; e.reg_write = 1; end
            5:  begin e.mem_req = 1; e.mem_write = 1; e.adr_src = 1; end
            6:  begin e.src_a = 2; e.alu = alu_exp(f3, ins[30], 1'b1); end
            7:  begin e.src_a = 2; e.src_b = 1; e.alu = alu_exp(f3, ins[30], 1'b0); end
            8:  e.reg_write = 1;
            9:  begin
                    e.src_a = 2; e.alu = 1;
                    e.pc_write = (f3 == 0) ? i_zero : (f3 == 1) ? !i_zero :
                                 (f3 == 4) ? lt : (f3 == 5) ? !lt :
                                 (f3 == 6) ? !i_carry : (f3 == 7) ? i_carry : 1'b0;
                end
            10: begin e.src_a = 1; e.src_b = 2; e.pc_write = 1; end
            11: begin e.src_a = 2; e.src_b = 1; end
            12: begin e.src_a = (ins[6:0] == OpLui) ? 3 : 1; e.src_b = 1; e.imm = 4; end
            default: ;
        endcase
        if (rst) begin
            e.mem_req = 0; e.mem_write = 0; e.ir_write = 0; e.pc_write = 0; e.reg_write = 0;
        end
        return e;
    endfunction

    initial forever begin
        outs_t e;
        @(negedge clk);
        e = expect_outs(m_st, i_instr, i_mem_ready, i_rst);
        chk("state", o_state, m_st);
        chk("fault", o_fault, m_fault);
        chk("mem_req", o_mem_req, e.mem_req);
        chk("mem_write", o_mem_write, e.mem_write);
        chk("adr_src", o_adr_src, e.adr_src);
        chk("ir_write", o_ir_write, e.ir_write);
        chk("pc_write", o_pc_write, e.pc_write);
        chk("reg_write", o_reg_write, e.reg_write);
        chk("result_src", o_result_src, e.result_src);
        chk("alu_src_a", o_alu_src_a, e.src_a);
        chk("alu_src_b", o_alu_src_b, e.src_b);
        chk("imm_src", o_imm_src, e.imm);
        chk("alu_control", o_alu_control, e.alu);
    end

    // ---------------- stimulus
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic b5, input logic [2:0] f3, input logic [6:0] op);
        return {1'b0, b5, 5'd0, 5'd2, 5'd1, f3, 5'd3, op};
    endfunction

    function automatic logic [4:0] strobes();
        return {o_mem_req, o_mem_write, o_ir_write, o_pc_write, o_reg_write};
    endfunction

    logic [6:0] ops [11] = '{OpLoad, OpStore, OpR, OpI, OpBranch, OpJal, OpJalr,
                             OpLui, OpAuipc, 7'b0000000, 7'b1111111};
    int add_states [5] = '{0, 1, 6, 8, 0};

    initial begin
        i_rst = 1'b1; i_instr = '0; i_mem_ready = 1'b0;
        i_zero = 0; i_neg = 0; i_carry = 0; i_ovf = 0;
        tick();
        tick();
        chk("rst_state", o_state, 0);
        chk("rst_strobes", strobes(), 0);
        chk("rst_fault", o_fault, 0);
        i_rst = 1'b0;

        // add x3,x1,x2 with ready tied high
        i_instr = 32'h002081B3; i_mem_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("add_state", o_state, add_states[k]);
            chk("add_reg_write", o_reg_write, (k == 3) ? 1 : 0);
            if (k == 2) chk("add_alu", o_alu_control, 0);
            if (k < 4) tick();
        end

        // bltu taken (no carry) then not taken, 3 cycles each
        for (int c = 0; c < 2; c++) begin
            i_instr = mk(1'b0, 3'b110, OpBranch); i_carry = c[0];
            tick(); tick(); #1;
            chk("bltu_state", o_state, 9);
            chk("bltu_pc_write", o_pc_write, c == 0 ? 1 : 0);
            tick(); #1;
            chk("bltu_done", o_state, 0);
        end

        // lw with three not-ready cycles in MEMREAD: 8 cycles
        i_instr = mk(1'b0, 3'b010, OpLoad);
        tick(); tick(); tick();
        i_mem_ready = 1'b0; #1;
        chk("lw_memread", o_state, 3);
        tick(); tick(); tick(); #1;
        chk("lw_hold", o_state, 3);
        i_mem_ready = 1'b1;
        tick(); #1;
        chk("lw_memwb_state", o_state, 4);
        chk("lw_result_src", o_result_src, 1);
        chk("lw_reg_write", o_reg_write, 1);
        tick(); #1;
        chk("lw_done", o_state, 0);

        // timeout: ready low from ALUWB onward, trap on the 5th edge
        i_instr = 32'h002081B3;
        tick(); tick(); tick();
        i_mem_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            chk("to_wait", o_state, 0);
        end
        tick(); #1;
        chk("to_trap", o_state, 13);
        chk("to_fault", o_fault, 1);
        i_mem_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick(); #1;
            chk("trap_strobes", strobes(), 0);
            chk("trap_hold", o_state, 13);
        end
        i_rst = 1'b1; #1;
        chk("to_rst_fault", o_fault, 0);
        tick();
        i_rst = 1'b0;

        // ready in the last allowed cycle wins
        i_mem_ready = 1'b0;
        tick(); tick(); tick();
        i_mem_ready = 1'b1;
        tick(); #1;
        chk("late_ready_state", o_state, 1);
        chk("late_ready_fault", o_fault, 0);
        tick(); tick(); tick();

        // illegal opcode
        i_instr = '0;
        tick(); #1;
        chk("ill_decode", o_state, 1);
        tick(); #1;
`ifdef CTRL_ILLEGAL_TRAP_EN
        chk("ill_state", o_state, 13);
        chk("ill_fault", o_fault, 1);
`else
        chk("ill_state", o_state, 0);
        chk("ill_fault", o_fault, 0);
`endif
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;

        // jalr interrupted by reset while in JAL
        i_instr = mk(1'b0, 3'b000, OpJalr);
        tick(); tick(); #1;
        chk("jalr_state", o_state, 11);
        tick(); #1;
        chk("jal_state", o_state, 10);
        chk("jal_pc_write", o_pc_write, 1);
        i_rst = 1'b1; #1;
        chk("jal_rst_strobes", strobes(), 0);
        chk("jal_rst_state", o_state, 0);
        tick();
        i_rst = 1'b0; #1;
        chk("jal_resume_fetch", o_state, 0);
        tick(); #1;
        chk("jal_resume_decode", o_state, 1);

        // randomized traffic
        for (int cyc = 0; cyc < 3000; cyc++) begin
            tick();
            if (i_rst) begin
                i_rst = 1'b0;
            end else if ((m_st == 13 && $urandom_range(0, 7) == 0) ||
                         $urandom_range(0, 299) == 0) begin
                i_rst = 1'b1;
            end
            if (m_st == 0) begin
                i_instr = $urandom;
                i_instr[6:0] = ops[$urandom_range(0, 10)];
            end
            {i_zero, i_neg, i_carry, i_ovf} = 4'($urandom);
            i_mem_ready = ($urandom_range(0, 4) != 0);
        end
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
